apb_reg_slave: RTL and testbench



---
 rtl/apb_reg_slave.sv | 182 ++++++++++++++++++
 tb/tb_apb_reg_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// APB register slave: RW control register bank plus read-only ID and transfer-count words.
// Latency: SETUP edge, then WAIT_CYC+1 ACCESS cycles, so WAIT_CYC=0 is the plain two-cycle APB transfer.
// Backpressure: pready_o is held low for WAIT_CYC ACCESS cycles; psel_i low in ACCESS abandons the transfer.
//
// Ports:
//   apb_clk, rst_n        clock and synchronous active-high reset (name kept, polarity is high)
//   psel_i .. pprot_i     APB requester side (pprot_i accepted but unused)
//   prdata_o, pready_o,   APB response, registered; prdata_o is non-zero only while
//   pslverr_o             pready_o is high on a successful read
//   reg_o                 current contents of the RW registers
//   wr_pulse_o            one-cycle pulse per register, the cycle after a committed write
module apb_reg_slave #(
  parameter int          APB_AW   = 11,
  parameter int          APB_DW   = 32,
  parameter int          REG_NUM  = 8,
  parameter int          WAIT_CYC = 0,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000,
  parameter logic [31:0] ID_VAL   = 32'hA2B0_0001
) (
  input  logic                        apb_clk,
  input  logic                        rst_n,
  input  logic                        psel_i,
  input  logic                        penable_i,
  input  logic                        pwrite_i,
  input  logic [APB_AW-1:0]           paddr_i,
  input  logic [APB_DW-1:0]           pwdata_i,
  input  logic [3:0]                  pstrb_i,
  input  logic [3:0]                  pprot_i,
  output logic [APB_DW-1:0]           prdata_o,
  output logic                        pready_o,
  output logic                        pslverr_o,
  output logic [REG_NUM-1:0][31:0]    reg_o,
  output logic [REG_NUM-1:0]          wr_pulse_o
);

  localparam int IDX_W = APB_AW - 2;
  localparam logic [IDX_W-1:0] ID_IDX  = IDX_W'(8);
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(9);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                   state;
  logic [3:0]               wait_cnt;
  logic [31:0]              xfer_cnt;
  logic [APB_AW-1:0]        addr_q;
  logic                     write_q;
  logic [APB_DW-1:0]        wdata_q;
  logic [3:0]               strb_q;
  logic [REG_NUM-1:0][31:0] regs;

  // Protection attribute carries no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^pprot_i;

  assign reg_o = regs;

  // Decode works on the live bus while IDLE (so a zero-wait response can be
  // registered at the SETUP edge) and on the captured request during ACCESS,
  // which makes bus changes during wait cycles irrelevant.
  logic [APB_AW-1:0] dec_addr;
  logic              dec_write;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_is_reg;
  logic              dec_is_id;
  logic              dec_is_cnt;
  logic              dec_err;
  logic [31:0]       dec_rdata;

  always_comb begin
    dec_addr   = (state == IDLE) ? paddr_i  : addr_q;
    dec_write  = (state == IDLE) ? pwrite_i : write_q;
    dec_idx    = dec_addr[APB_AW-1:2];
    dec_is_reg = (dec_idx < IDX_W'(REG_NUM));
    dec_is_id  = (dec_idx == ID_IDX);
    dec_is_cnt = (dec_idx == CNT_IDX);
    dec_err    = (dec_addr[1:0] != 2'b00)
              || !(dec_is_reg || dec_is_id || dec_is_cnt)
              || (dec_write && (dec_is_id || dec_is_cnt));
    dec_rdata  = '0;
    if (!dec_write && !dec_err) begin
      if (dec_is_id) begin
        dec_rdata = ID_VAL;
      end else if (dec_is_cnt) begin
        // Counter value before this transfer's own increment.
        dec_rdata = xfer_cnt;
      end else begin
        for (int i = 0; i < REG_NUM; i++) begin
          if (dec_idx == IDX_W'(i)) begin
            dec_rdata = regs[i];
          end
        end
      end
    end
  end

  always_ff @(posedge apb_clk) begin
    if (rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      xfer_cnt   <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      pready_o   <= 1'b0;
      pslverr_o  <= 1'b0;
      prdata_o   <= '0;
      wr_pulse_o <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= RST_VAL;
      end
    end else begin
      wr_pulse_o <= '0;
      case (state)
        IDLE: begin
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          prdata_o  <= '0;
          // penable_i without a preceding SETUP is simply not a SETUP.
          if (psel_i && !penable_i) begin
            addr_q   <= paddr_i;
            write_q  <= pwrite_i;
            wdata_q  <= pwdata_i;
            strb_q   <= pstrb_i;
            wait_cnt <= 4'(WAIT_CYC);
            state    <= ACCESS;
            if (WAIT_CYC == 0) begin
              pready_o  <= 1'b1;
              pslverr_o <= dec_err;
              prdata_o  <= dec_rdata;
            end
          end
        end

        ACCESS: begin
          if (!psel_i) begin
            // Abandoned transfer: no commit, counter untouched.
            state     <= IDLE;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= '0;
          end else if (pready_o) begin
            if (penable_i) begin
              if (write_q && !dec_err) begin
                for (int i = 0; i < REG_NUM; i++) begin
                  if (addr_q[APB_AW-1:2] == IDX_W'(i)) begin
                    for (int k = 0; k < 4; k++) begin
                      if (strb_q[k]) begin
                        regs[i][8*k +: 8] <= wdata_q[8*k +: 8];
                      end
                    end
                    wr_pulse_o[i] <= 1'b1;
                  end
                end
              end
              xfer_cnt  <= xfer_cnt + 32'd1;
              state     <= IDLE;
              pready_o  <= 1'b0;
              pslverr_o <= 1'b0;
              prdata_o  <= '0;
            end
          end else begin
            // pready_o is registered, so the response is loaded on the
            // edge where the counter steps from 1 to 0.
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              pready_o  <= 1'b1;
              pslverr_o <= dec_err;
              prdata_o  <= dec_rdata;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Testbench for apb_reg_slave: two instances (zero-wait/8 regs and 3-wait/6 regs) on one clock.
// Directed steps from the feature list, then randomized transfers against a register-map model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_apb_reg_slave;

  localparam logic [31:0] ID = 32'hA2B0_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        psel0, psel3, penable, pwrite;
  logic [10:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb, pprot;

  logic [31:0]      prdata0, prdata3;
  logic             pready0, pready3, pslverr0, pslverr3;
  logic [7:0][31:0] reg0;
  logic [5:0][31:0] reg3;
  logic [7:0]       wp0;
  logic [5:0]       wp3;

  apb_reg_slave #(.REG_NUM(8), .WAIT_CYC(0)) u_w0 (
    .apb_clk(clk), .rst_n(rst), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
    .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0), .reg_o(reg0), .wr_pulse_o(wp0)
  );

  apb_reg_slave #(.REG_NUM(6), .WAIT_CYC(3)) u_w3 (
    .apb_clk(clk), .rst_n(rst), .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
    .prdata_o(prdata3), .pready_o(pready3), .pslverr_o(pslverr3), .reg_o(reg3), .wr_pulse_o(wp3)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents and completed-transfer count per instance.
  logic [31:0] mdl [2][8];
  logic [31:0] cnt [2];
  int          nreg  [2] = '{8, 6};
  int          nwait [2] = '{0, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(int d);
    return (d == 0) ? pready0 : pready3;
  endfunction

  function automatic logic get_err(int d);
    return (d == 0) ? pslverr0 : pslverr3;
  endfunction

  function automatic logic [31:0] get_rd(int d);
    return (d == 0) ? prdata0 : prdata3;
  endfunction

  function automatic logic [7:0] get_wp(int d);
    return (d == 0) ? wp0 : {2'b00, wp3};
  endfunction

  function automatic logic [31:0] get_reg(int d, int i);
    if (d == 0) return reg0[i[2:0]];
    if (i < 6) return reg3[i[2:0]];
    return 32'h0;
  endfunction

  task automatic set_psel(input int d, input logic v);
    if (d == 0) psel0 = v;
    else psel3 = v;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mdl[d][i] = 32'h0;
      cnt[d] = 32'h0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_pulse0", 32'(wp0), 32'd0);
      chk("idle_pulse3", 32'(wp3), 32'd0);
      chk("idle_ready0", 32'(pready0), 32'd0);
      chk("idle_ready3", 32'(pready3), 32'd0);
    end
  endtask

  // One complete transfer, entered on a falling edge; returns on the falling
  // edge after the completion edge with the bus idle (caller may start the
  // next SETUP immediately for back-to-back traffic).
  task automatic xfer(input int d, input logic wr, input logic [10:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er);
    logic [8:0]  idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [7:0]  exp_wp;
    int          waits;
    idx     = a[10:2];
    exp_err = (a[1:0] != 2'b00)
           || !((int'(idx) < nreg[d]) || idx == 9'd8 || idx == 9'd9)
           || (wr && idx >= 9'd8);
    exp_rd  = 32'h0;
    if (!wr && !exp_err) begin
      if (idx == 9'd8)      exp_rd = ID;
      else if (idx == 9'd9) exp_rd = cnt[d];
      else                  exp_rd = mdl[d][idx[2:0]];
    end
    exp_wp = (wr && !exp_err) ? (8'd1 << idx[2:0]) : 8'd0;

    set_psel(d, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    @(negedge clk);
    penable = 1'b1;
    chk("pulse_clear", 32'(get_wp(d)), 32'd0);
    waits = 0;
    while (!get_rdy(d) && waits < 40) begin
      if (int'(idx) < nreg[d]) chk("reg_hold_wait", get_reg(d, int'(idx)), mdl[d][idx[2:0]]);
      // Bus noise during wait cycles must not reach the captured request.
      paddr  = 11'($urandom);
      pwdata = $urandom;
      pstrb  = 4'($urandom);
      pwrite = 1'($urandom);
      waits++;
      @(negedge clk);
    end
    chk("wait_cycles", 32'(waits), 32'(nwait[d]));
    chk("pslverr", 32'(get_err(d)), 32'(exp_err));
    chk("prdata", get_rd(d), exp_rd);
    if (int'(idx) < nreg[d]) chk("reg_hold_ready", get_reg(d, int'(idx)), mdl[d][idx[2:0]]);
    rd = get_rd(d);
    er = get_err(d);
    @(negedge clk);
    if (wr && !exp_err) begin
      for (int k = 0; k < 4; k++) begin
        if (st[k]) mdl[d][idx[2:0]][8*k +: 8] = wd[8*k +: 8];
      end
    end
    cnt[d] = cnt[d] + 32'd1;
    chk("wr_pulse", 32'(get_wp(d)), 32'(exp_wp));
    chk("ready_drop", 32'(get_rdy(d)), 32'd0);
    for (int i = 0; i < nreg[d]; i++) chk("reg_o", get_reg(d, i), mdl[d][i]);
    set_psel(d, 1'b0);
    penable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [8:0]  ridx;
    logic [1:0]  lo;
    int          d;

    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 4'h5;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(pready0), 32'd0);
    chk("rst_ready3", 32'(pready3), 32'd0);
    chk("rst_err0", 32'(pslverr0), 32'd0);
    chk("rst_rdata0", prdata0, 32'd0);
    chk("rst_pulse0", 32'(wp0), 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_reg0", reg0[i], 32'd0);
    for (int i = 0; i < 6; i++) chk("rst_reg3", reg3[i], 32'd0);
    rst = 1'b0;

    // Zero-wait reads of reg 0 and ID.
    xfer(0, 1'b0, 11'h000, 32'h0, 4'h0, rd, er);
    chk("read0_data", rd, 32'h0000_0000);
    chk("read0_err", 32'(er), 32'd0);
    idle(1);
    xfer(0, 1'b0, 11'h020, 32'h0, 4'h0, rd, er);
    chk("id_data", rd, 32'hA2B0_0001);

    // Strobed write then readback.
    idle(1);
    xfer(0, 1'b1, 11'h004, 32'h1234_5678, 4'b0101, rd, er);
    chk("strb_pulse", 32'(wp0), 32'h0000_0002);
    idle(1);
    xfer(0, 1'b0, 11'h004, 32'h0, 4'hF, rd, er);
    chk("strb_data", rd, 32'h0034_0078);

    // Wait-state write on the 3-wait instance.
    idle(1);
    xfer(1, 1'b1, 11'h008, 32'hCAFE_F00D, 4'hF, rd, er);
    chk("wait_reg2", reg3[2], 32'hCAFE_F00D);

    // Error responses.
    idle(1);
    xfer(0, 1'b1, 11'h024, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("err_wr_cnt", 32'(er), 32'd1);
    idle(1);
    xfer(0, 1'b0, 11'h002, 32'h0, 4'h0, rd, er);
    chk("err_misalign", 32'(er), 32'd1);
    chk("err_misalign_data", rd, 32'd0);
    idle(1);
    xfer(0, 1'b0, 11'h030, 32'h0, 4'h0, rd, er);
    chk("err_unmapped", 32'(er), 32'd1);
    idle(1);
    xfer(1, 1'b0, 11'h018, 32'h0, 4'h0, rd, er);
    chk("err_above_regnum", 32'(er), 32'd1);
    idle(1);
    xfer(0, 1'b1, 11'h014, 32'h0, 4'h0, rd, er);
    chk("zero_strb_pulse", 32'(wp0), 32'h0000_0020);

    // Back-to-back write then read, no idle cycle.
    idle(1);
    xfer(0, 1'b1, 11'h00C, 32'h8765_4321, 4'hF, rd, er);
    xfer(0, 1'b0, 11'h00C, 32'h0, 4'h0, rd, er);
    chk("b2b_data", rd, 32'h8765_4321);
    xfer(0, 1'b0, 11'h024, 32'h0, 4'h0, rd, er);
    chk("cnt_running", rd, 32'd10);

    // PENABLE without SETUP is ignored.
    psel0 = 1'b1; penable = 1'b1; paddr = 11'h000; pwrite = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_setup_ready", 32'(pready0), 32'd0);
    end
    psel0 = 1'b0; penable = 1'b0;
    idle(1);

    // Abort during the second wait cycle.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 11'h004; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    chk("abort_w1_ready", 32'(pready3), 32'd0);
    @(negedge clk);
    chk("abort_w2_ready", 32'(pready3), 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(pready3), 32'd0);
    chk("abort_pulse", 32'(wp3), 32'd0);
    idle(2);
    for (int i = 0; i < 6; i++) chk("abort_reg", reg3[i], mdl[1][i]);
    xfer(1, 1'b0, 11'h024, 32'h0, 4'h0, rd, er);
    chk("abort_cnt", rd, 32'd2);

    // Reset in the middle of ACCESS on both instances.
    idle(1);
    psel0 = 1'b1; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 11'h020;
    @(negedge clk);
    penable = 1'b1;
    chk("pre_rst_id", prdata0, ID);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    model_reset();
    chk("mid_rst_ready0", 32'(pready0), 32'd0);
    chk("mid_rst_rdata0", prdata0, 32'd0);
    chk("mid_rst_err0", 32'(pslverr0), 32'd0);
    chk("mid_rst_ready3", 32'(pready3), 32'd0);
    chk("mid_rst_rdata3", prdata3, 32'd0);
    chk("mid_rst_pulse3", 32'(wp3), 32'd0);
    for (int i = 0; i < 8; i++) chk("mid_rst_reg0", reg0[i], 32'd0);
    for (int i = 0; i < 6; i++) chk("mid_rst_reg3", reg3[i], 32'd0);
    idle(1);

    // Five transfers, then the counter reads 5.
    for (int i = 0; i < 5; i++) begin
      xfer(1, 1'b1, 11'(i * 4), $urandom, 4'hF, rd, er);
    end
    xfer(1, 1'b0, 11'h024, 32'h0, 4'h0, rd, er);
    chk("cnt_after5", rd, 32'd5);
    idle(1);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      d    = int'($urandom_range(0, 1));
      ridx = 9'($urandom_range(0, 11));
      lo   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      xfer(d, 1'($urandom), {ridx, lo}, $urandom, 4'($urandom), rd, er);
      if ($urandom_range(0, 1) == 0) idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
